program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 0, halfword address of the first instruction written.
REQ-002 Parameter MAX_HALFWORDS, default 512, instruction memory capacity in halfwords.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  one-cycle request to begin a load session.
REQ-006 byte_valid_i  input  1  byte_i holds a valid byte.
REQ-007 byte_i  input  8  incoming serial-link byte.
REQ-008 byte_ready_o  output  1  loader accepts byte_i this cycle; a byte transfers when valid and ready are both high.
REQ-009 program_mem_write_en_o  output  1  one-cycle write strobe to the instruction memory program port.
REQ-010 instruction_o  output  HALF_WORD  instruction data for the write.
REQ-011 instruction_addr_o  output  WORD  halfword address for the write.
REQ-012 loading_o  output  1  session in progress; the core is held in reset while it is high.
REQ-013 done_o  output  1  last session completed without error; sticky.
REQ-014 error_o  output  1  last session aborted; sticky.

Function
REQ-015 States SHALL be IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE.
REQ-016 IDLE: start_i moves to LEN_LO and clears done_o and error_o; start_i is ignored in every other state.
REQ-017 LEN_LO/LEN_HI: each accepts one byte, forming a 16-bit little-endian halfword count N.
REQ-018 After LEN_HI: N == 0 goes to CHECK; N > MAX_HALFWORDS sets error_o and goes to IDLE; otherwise goes to DATA_LO.
REQ-019 DATA_LO accepts instruction bits [7:0]; DATA_HI accepts bits [15:8] and then goes to WRITE.
REQ-020 WRITE lasts exactly one cycle, with program_mem_write_en_o=1, instruction_o = the assembled halfword, and instruction_addr_o = BASE_ADDR + index.
REQ-021 After WRITE: index increments; index == N goes to CHECK, else back to DATA_LO.
REQ-022 byte_ready_o SHALL be 1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI, and CHECK (when checksum is enabled); the state advances only on a handshake.
REQ-023 Latency: the write strobe is asserted exactly one cycle after the DATA_HI handshake.
REQ-024 program_mem_write_en_o SHALL be 0 outside WRITE; instruction_o and instruction_addr_o hold their last values between writes.
REQ-025 loading_o SHALL be 1 in every state except IDLE and DONE.
REQ-026 DONE sets done_o and returns to IDLE on the next cycle.
REQ-027 Index and address arithmetic SHALL be WORD wide with no wrap; N <= MAX_HALFWORDS guarantees in-range addresses.

Reset
REQ-028 On reset_i: state = IDLE, index = 0, and byte_ready_o, program_mem_write_en_o, loading_o, done_o, error_o = 0.
REQ-029 On reset_i: instruction_o = 0 and instruction_addr_o = BASE_ADDR.
REQ-030 Reset mid-session SHALL abandon the session immediately with no write strobe; memory contents already written are left unchanged.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN: when defined, the loader XORs every length and data byte and CHECK accepts one trailer byte.
REQ-032 With LOADER_CHECKSUM_EN, a trailer equal to the running XOR goes to DONE; a mismatch sets error_o, leaves done_o 0, and goes to IDLE.
REQ-033 Without LOADER_CHECKSUM_EN, CHECK consumes no byte and goes to DONE in one cycle.

Structure
REQ-034 WORD, HALF_WORD, and the loader_state_t enum typedef SHALL live in the shared GENERAL_DEFS package.
REQ-035 The XOR accumulator SHALL be a sub-module, loader_checksum, instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-036 Pulse start_i, then send bytes 02 00 34 12 78 56 -> writes 0x1234@0 and 0x5678@1, done_o=1, loading_o=0.
REQ-037 Send length 00 00 -> no write strobe, done_o=1 within 2 cycles after LEN_HI.
REQ-038 Send length 01 02 (N=513) -> error_o=1, no write, back in IDLE.
REQ-039 Random byte_valid_i gaps and start_i pulsed mid-session -> write sequence identical to the gap-free run, start_i ignored.
REQ-040 Assert reset_i one cycle after the first DATA_HI handshake -> no write strobe, all outputs at reset values.
REQ-041 With LOADER_CHECKSUM_EN: length 01 00, data AA 55, trailer FE -> done_o=1; trailer 00 -> error_o=1, done_o=0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module   : GENERAL_DEFS (package)
// Brief    : Shared widths and loader state type for the program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package GENERAL_DEFS;

    localparam int WORD      = 32;
    localparam int HALF_WORD = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_LO  = 3'd1,
        LEN_HI  = 3'd2,
        DATA_LO = 3'd3,
        DATA_HI = 3'd4,
        WRITE   = 3'd5,
        CHECK   = 3'd6,
        DONE    = 3'd7
    } loader_state_t;

    // The core stays in reset for the whole session, including CHECK.
    function automatic logic state_is_loading(input loader_state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader_checksum.sv
// ============================================================================
// Module   : loader_checksum
// Brief    : Running XOR of accepted loader bytes; built only when
//            LOADER_CHECKSUM_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifdef LOADER_CHECKSUM_EN
module loader_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    logic [7:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_sum <= 8'h00;
        end else if (en) begin
            r_sum <= r_sum ^ data;
        end
    end

    assign sum = r_sum;

endmodule
`endif

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Brief    : Serial-link boot loader writing halfwords into instruction memory.
//            Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader
    import GENERAL_DEFS::*;
#(
    parameter logic [WORD-1:0] BASE_ADDR     = '0,
    parameter int              MAX_HALFWORDS = 512
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_i,
    output logic                 byte_ready_o,
    output logic                 program_mem_write_en_o,
    output logic [HALF_WORD-1:0] instruction_o,
    output logic [WORD-1:0]      instruction_addr_o,
    output logic                 loading_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam logic [WORD-1:0] c_max_len = WORD'(MAX_HALFWORDS);

    loader_state_t        r_state;
    logic [7:0]           r_byte_lo;
    logic [HALF_WORD-1:0] r_len;
    logic [WORD-1:0]      r_index;
    logic [HALF_WORD-1:0] r_instruction;
    logic [WORD-1:0]      r_instruction_addr;
    logic                 r_done;
    logic                 r_error;

    logic                 w_handshake;
    logic [HALF_WORD-1:0] w_assembled;
    logic [WORD-1:0]      w_index_next;
    logic                 w_check_ready;
    logic                 w_check_ok;

    assign w_handshake  = byte_valid_i && byte_ready_o;
    assign w_assembled  = {byte_i, r_byte_lo};
    assign w_index_next = r_index + WORD'(1);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] w_sum;

    loader_checksum u_checksum (
        .clk   (clk_i),
        .rst   (reset_i),
        .clear ((r_state == IDLE) && start_i),
        .en    (w_handshake && (r_state != CHECK)),
        .data  (byte_i),
        .sum   (w_sum)
    );

    assign w_check_ready = 1'b1;
    assign w_check_ok    = (byte_i == w_sum);
`else
    assign w_check_ready = 1'b0;
    assign w_check_ok    = 1'b1;
`endif

    always_comb begin
        byte_ready_o = 1'b0;
        case (r_state)
            LEN_LO, LEN_HI, DATA_LO, DATA_HI: byte_ready_o = 1'b1;
            CHECK:                            byte_ready_o = w_check_ready;
            default:                          byte_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state            <= IDLE;
            r_byte_lo          <= 8'h00;
            r_len              <= '0;
            r_index            <= '0;
            r_instruction      <= '0;
            r_instruction_addr <= BASE_ADDR;
            r_done             <= 1'b0;
            r_error            <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= LEN_LO;
                        r_index <= '0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (w_handshake) begin
                        r_byte_lo <= byte_i;
                        r_state   <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_handshake) begin
                        r_len <= w_assembled;
                        if (w_assembled == '0) begin
                            r_state <= CHECK;
                        end else if (WORD'(w_assembled) > c_max_len) begin
                            r_error <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_state <= DATA_LO;
                        end
                    end
                end
                DATA_LO: begin
                    if (w_handshake) begin
                        r_byte_lo <= byte_i;
                        r_state   <= DATA_HI;
                    end
                end
                DATA_HI: begin
                    // Capture here so data/address are stable through WRITE and after.
                    if (w_handshake) begin
                        r_instruction      <= w_assembled;
                        r_instruction_addr <= BASE_ADDR + r_index;
                        r_state            <= WRITE;
                    end
                end
                WRITE: begin
                    r_index <= w_index_next;
                    r_state <= (w_index_next == WORD'(r_len)) ? CHECK : DATA_LO;
                end
                CHECK: begin
                    if (!w_check_ready || w_handshake) begin
                        if (w_check_ok) begin
                            r_state <= DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gated by reset so a reset landing on the WRITE cycle never strobes memory.
    assign program_mem_write_en_o = (r_state == WRITE) && !reset_i;
    assign instruction_o          = r_instruction;
    assign instruction_addr_o     = r_instruction_addr;
    assign loading_o              = state_is_loading(r_state);
    assign done_o                 = r_done;
    assign error_o                = r_error;

endmodule

`default_nettype wire
